// File: rtl/sigmoid_layer_sequencer.sv
// Sequences the shared 4-lane sigmoid ALU through one fully-connected layer.
// Streams weight/input groups per neuron and captures each sigmoid result.
module sigmoid_layer_sequencer #(
  parameter int NUM_NEURONS = 16,
  parameter int NUM_GROUPS  = 196,
  parameter int MEM_LAT     = 1,
  localparam int NW = $clog2(NUM_NEURONS),
  localparam int GW = $clog2(NUM_GROUPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [GW-1:0] group_idx,
  output logic [NW-1:0] neuron_idx,
  output logic          alu_clear,
  output logic          alu_accumulate,
  input  logic [3:0]    sigmoid_out,
  output logic          res_valid,
  output logic [NW-1:0] res_neuron,
  output logic [3:0]    res_data
);

  localparam int D  = MEM_LAT + 3;
  localparam int CW = $clog2(D + 1);

  localparam logic [GW-1:0] G_LAST = GW'(NUM_GROUPS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);
  localparam logic [CW-1:0] D_LAST = CW'(D);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        state;
  logic [GW-1:0] gcnt;
  logic [CW-1:0] dcnt;
  logic [D-1:0]  dline;

  assign rd_en          = (state == S_ISSUE) && !stall;
  assign group_idx      = gcnt;
  // accumulate lines up with the data addressed D cycles earlier
  assign alu_accumulate = dline[D-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gcnt       <= '0;
      dcnt       <= '0;
      dline      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      neuron_idx <= '0;
      alu_clear  <= 1'b0;
      res_valid  <= 1'b0;
      res_neuron <= '0;
      res_data   <= '0;
    end else begin
      dline     <= {dline[D-2:0], rd_en};
      alu_clear <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLEAR;
            busy       <= 1'b1;
            alu_clear  <= 1'b1;
            neuron_idx <= '0;
          end
        end
        S_CLEAR: begin
          gcnt  <= '0;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!stall) begin
            if (gcnt == G_LAST) begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) state <= S_CAPTURE;
          else dcnt <= dcnt + 1'b1;
        end
        S_CAPTURE: begin
          res_data   <= sigmoid_out;
          res_neuron <= neuron_idx;
          res_valid  <= 1'b1;
          if (neuron_idx != N_LAST) begin
            neuron_idx <= neuron_idx + 1'b1;
            alu_clear  <= 1'b1;
            state      <= S_CLEAR;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_layer_sequencer.sv
// Bench for sigmoid_layer_sequencer: schedule model built from start/stall
// traces, compared against the DUT every cycle, plus directed literal checks.
module tb_sigmoid_layer_sequencer;
  localparam int NN = 2;
  localparam int NG = 2;
  localparam int ML = 1;
  localparam int D = ML + 3;
  localparam int NW = $clog2(NN);
  localparam int GW = $clog2(NG);
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst, start, stall;
  logic [3:0] sigmoid_out;
  logic busy, done, rd_en, alu_clear, alu_accumulate, res_valid;
  logic [GW-1:0] group_idx;
  logic [NW-1:0] neuron_idx, res_neuron;
  logic [3:0] res_data;

  sigmoid_layer_sequencer #(
    .NUM_NEURONS(NN), .NUM_GROUPS(NG), .MEM_LAT(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en), .group_idx(group_idx),
    .neuron_idx(neuron_idx), .alu_clear(alu_clear),
    .alu_accumulate(alu_accumulate), .sigmoid_out(sigmoid_out),
    .res_valid(res_valid), .res_neuron(res_neuron), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit st_a[MAXC];
  bit sl_a[MAXC];
  logic [3:0] sg_a[MAXC];
  bit e_rd[MAXC], e_clr[MAXC], e_acc[MAXC], e_rv[MAXC];
  bit e_done[MAXC], e_busy[MAXC];
  int e_gi[MAXC], e_ni[MAXC], e_rn[MAXC], e_dat[MAXC];
  bit g_rv[MAXC], g_done[MAXC], g_acc[MAXC], g_busy[MAXC];
  int g_dat[MAXC], g_rn[MAXC];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp, input int c);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && alu_clear && alu_accumulate) begin
      fails++;
      $display("FAIL clr_acc_overlap at %0t: got 1 expected 0", $time);
    end

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_a[i] = 1'b0;
      sl_a[i] = 1'b0;
      sg_a[i] = 4'($urandom);
    end
  endtask

  // Event schedule: clear, then NG non-stalled issues, capture at L+D+2.
  task automatic build_model(input int n);
    int c, t, u, g, l, cap;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_clr[i] = 0; e_acc[i] = 0; e_rv[i] = 0;
      e_done[i] = 0; e_busy[i] = 0;
      e_gi[i] = 0; e_ni[i] = 0; e_rn[i] = 0; e_dat[i] = 0;
    end
    c = 0;
    while (c < n) begin
      if (st_a[c]) begin
        t = c + 1;
        for (int nn = 0; nn < NN; nn++) begin
          e_clr[t] = 1;
          for (int k = t; k < MAXC; k++) e_ni[k] = nn;
          g = 0; u = t + 1; l = u;
          while (g < NG) begin
            if (!sl_a[u]) begin
              e_rd[u] = 1; e_gi[u] = g; e_acc[u + D] = 1;
              l = u; g++;
            end
            u++;
          end
          cap = l + D + 2;
          e_rv[cap + 1] = 1;
          for (int k = cap + 1; k < MAXC; k++) begin
            e_dat[k] = int'(sg_a[cap]);
            e_rn[k] = nn;
          end
          t = cap + 1;
        end
        e_done[t] = 1;
        for (int k = c + 1; k <= t; k++) e_busy[k] = 1;
        c = t + 1;
      end else begin
        c++;
      end
    end
  endtask

  task automatic run(input int n, input bit do_rst);
    if (do_rst) begin
      rst = 1; start = 0; stall = 0;
      @(posedge clk); #1 rst = 0;
    end
    for (int c = 0; c < n; c++) begin
      start = st_a[c]; stall = sl_a[c]; sigmoid_out = sg_a[c];
      @(negedge clk);
      g_rv[c] = res_valid; g_done[c] = done; g_acc[c] = alu_accumulate;
      g_busy[c] = busy; g_dat[c] = int'(res_data); g_rn[c] = int'(res_neuron);
      chk("rd_en", 32'(rd_en), 32'(e_rd[c]), c);
      if (e_rd[c]) chk("group_idx", 32'(group_idx), 32'(e_gi[c]), c);
      chk("alu_clear", 32'(alu_clear), 32'(e_clr[c]), c);
      chk("alu_accumulate", 32'(alu_accumulate), 32'(e_acc[c]), c);
      chk("res_valid", 32'(res_valid), 32'(e_rv[c]), c);
      chk("res_neuron", 32'(res_neuron), 32'(e_rn[c]), c);
      chk("res_data", 32'(res_data), 32'(e_dat[c]), c);
      chk("done", 32'(done), 32'(e_done[c]), c);
      chk("busy", 32'(busy), 32'(e_busy[c]), c);
      chk("neuron_idx", 32'(neuron_idx), 32'(e_ni[c]), c);
      @(posedge clk); #1;
    end
    start = 0; stall = 0;
  endtask

  int cnt_a, cnt_b;

  initial begin
    rst = 1; start = 0; stall = 0; sigmoid_out = 4'd0;
    #1;
    chk("reset_busy", 32'(busy), 0, 0);
    chk("reset_rd_en", 32'(rd_en), 0, 0);
    chk("reset_acc", 32'(alu_accumulate), 0, 0);

    // Nominal layer with distinct sigmoid values per neuron
    clear_stim();
    st_a[0] = 1;
    for (int i = 0; i < MAXC; i++) sg_a[i] = (i < 10) ? 4'b0110 : 4'b1000;
    build_model(30);
    chk("model_clr1", 32'(e_clr[1]), 1, 1);
    chk("model_rd2", 32'(e_rd[2]), 1, 2);
    chk("model_rd3", 32'(e_rd[3]), 1, 3);
    chk("model_acc6", 32'(e_acc[6]), 1, 6);
    chk("model_acc7", 32'(e_acc[7]), 1, 7);
    chk("model_rv10", 32'(e_rv[10]), 1, 10);
    chk("model_done19", 32'(e_done[19]), 1, 19);
    chk("model_busy20", 32'(e_busy[20]), 0, 20);
    run(30, 1);
    chk("s1_rv10", 32'(g_rv[10]), 1, 10);
    chk("s1_rn10", 32'(g_rn[10]), 0, 10);
    chk("s1_dat10", 32'(g_dat[10]), 32'(4'b0110), 10);
    chk("s1_rn19", 32'(g_rn[19]), 1, 19);
    chk("s1_dat19", 32'(g_dat[19]), 32'(4'b1000), 19);
    chk("s1_done19", 32'(g_done[19]), 1, 19);
    chk("s1_busy20", 32'(g_busy[20]), 0, 20);
    cnt_a = 0;
    for (int i = 0; i < 30; i++) cnt_a += int'(g_acc[i]);
    chk("s1_acc_count", 32'(cnt_a), NG * NN, 29);

    // One stall cycle during issue
    clear_stim();
    st_a[0] = 1; sl_a[3] = 1;
    build_model(30);
    chk("model_s2_acc6", 32'(e_acc[6]), 1, 6);
    chk("model_s2_acc7", 32'(e_acc[7]), 0, 7);
    chk("model_s2_acc8", 32'(e_acc[8]), 1, 8);
    chk("model_s2_done20", 32'(e_done[20]), 1, 20);
    run(30, 1);

    // start while busy is ignored
    clear_stim();
    st_a[0] = 1; st_a[5] = 1;
    build_model(40);
    run(40, 1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      cnt_a += int'(g_rv[i]);
      cnt_b += int'(g_done[i]);
    end
    chk("s4_rv_count", 32'(cnt_a), NN, 39);
    chk("s4_done_count", 32'(cnt_b), 1, 39);

    // Reset in cycle 7, mid-drain while accumulate is high
    rst = 1; start = 0; stall = 0;
    @(posedge clk); #1 rst = 0;
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("s5_pre_acc", 32'(alu_accumulate), 1, 7);
    rst = 1;
    #1;
    chk("s5_busy", 32'(busy), 0, 7);
    chk("s5_done", 32'(done), 0, 7);
    chk("s5_rd_en", 32'(rd_en), 0, 7);
    chk("s5_clr", 32'(alu_clear), 0, 7);
    chk("s5_acc", 32'(alu_accumulate), 0, 7);
    chk("s5_rv", 32'(res_valid), 0, 7);
    chk("s5_nidx", 32'(neuron_idx), 0, 7);
    chk("s5_gidx", 32'(group_idx), 0, 7);
    chk("s5_rdat", 32'(res_data), 0, 7);
    @(posedge clk); #1 rst = 0;
    cnt_a = 0;
    repeat (30) begin
      @(negedge clk);
      cnt_a += int'(res_valid) + int'(done) + int'(alu_accumulate);
    end
    chk("s5_quiet", 32'(cnt_a), 0, 0);
    @(posedge clk); #1;
    clear_stim();
    st_a[0] = 1;
    build_model(30);
    run(30, 0);

    // Randomised start/stall traffic
    for (int r = 0; r < 8; r++) begin
      clear_stim();
      for (int c = 0; c < 200; c++) begin
        st_a[c] = ($urandom_range(0, 7) == 0);
        sl_a[c] = ($urandom_range(0, 3) == 0);
      end
      build_model(200);
      run(200, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sigmoid_layer_sequencer.md
Name: sigmoid_layer_sequencer

Overview:
Sequences the shared 4-lane sigmoid ALU through one fully-connected layer: for each neuron it clears the accumulator and streams NUM_GROUPS groups of 4 weight/input nibbles from synchronous memories. It times alu_accumulate to match the ALU pipeline, then captures the 4-bit sigmoid result. It sits between the top-level control FSM (start/done) and the weight/input/bias memories plus the sigmoid ALU. Results go to the sigmoid result registers through a valid-qualified write port.

Parameters:
NUM_NEURONS, 16, neurons per layer (bias address range 0..NUM_NEURONS-1)
NUM_GROUPS, 196, 4-input groups per neuron (784 inputs / 4)
MEM_LAT, 1, read latency in cycles from rd_en/address to data at ALU inputs
NW, $clog2(NUM_NEURONS), neuron index width (local)
GW, $clog2(NUM_GROUPS), group index width (local)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins layer when idle, ignored when busy
stall  in  1  memory not ready; suppresses issue in the current cycle
busy  out  1  high from cycle after accepted start until done pulse inclusive
done  out  1  one-cycle pulse after last neuron's result is written
rd_en  out  1  group read strobe to weight/input memories
group_idx  out  GW  group address, valid when rd_en=1
neuron_idx  out  NW  current neuron; weight row and bias address, held for whole neuron
alu_clear  out  1  ALU accumulator clear
alu_accumulate  out  1  ALU accumulate enable
sigmoid_out  in  4  ALU registered sigmoid output
res_valid  out  1  one-cycle result write strobe
res_neuron  out  NW  neuron index for res_data
res_data  out  4  captured sigmoid value

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, counters=0, accumulate delay line=0. All outputs 0.
- Constant D = MEM_LAT+3: ALU input register, multiplier register and adder register stages plus memory latency. Data addressed in cycle c must have alu_accumulate=1 in cycle c+D.
- Delay line: D-bit shift register fed by rd_en each cycle. alu_accumulate = its oldest bit. Stall inserts zeros, so no bubble is ever accumulated.
- States:
  - IDLE: start=1 -> CLEAR with neuron_idx=0.
  - CLEAR (1 cycle): alu_clear=1, rd_en=0, group counter=0 -> ISSUE.
  - ISSUE:
    - stall=0: rd_en=1, group_idx=counter, counter++.
    - stall=1: rd_en=0, counter held.
    - On issuing group NUM_GROUPS-1 -> DRAIN. Call that cycle L.
  - DRAIN: rd_en=0; lasts D+1 cycles (L+1..L+D+1), using a drain counter. stall ignored.
  - CAPTURE (cycle L+D+2): at the clock edge, res_data<=sigmoid_out, res_neuron<=neuron_idx, res_valid<=1 (pulse visible in the next cycle).
    - neuron_idx<NUM_NEURONS-1: neuron_idx++ -> CLEAR.
    - Otherwise -> DONE.
  - DONE (1 cycle): done=1, busy=1 -> IDLE. busy falls in the following cycle.
- Timing of the last accumulate: in cycle L+D. accum_out updates at the end of L+D; the ALU registers sigmoid at the end of L+D+1; CAPTURE samples it in L+D+2.
- Cycles per neuron with no stalls: NUM_GROUPS+D+3. Each stall cycle adds one.
- The res_valid pulse for neuron n coincides with CLEAR of neuron n+1 (or with DONE). This is legal; the result register path is independent.
- alu_clear and alu_accumulate are never high in the same cycle. This holds because DRAIN empties the delay line before CLEAR.
- neuron_idx is held from CLEAR through CAPTURE, so the bias memory output is stable when the ALU bias register samples it.
- start while busy: ignored, no restart.
- rst mid-layer: immediate return to IDLE. No res_valid or done is generated. The ALU accumulator is not cleared here; the next CLEAR handles it.
- All outputs are registered except alu_accumulate (delay-line tap, itself a flop), rd_en and group_idx (decoded from state and counter).

Test Plan:
1. NUM_NEURONS=2, NUM_GROUPS=2, MEM_LAT=1, start at cycle 0:
   - alu_clear in cycle 1; rd_en cycles 2-3 (group_idx 0,1); alu_accumulate cycles 6-7.
   - CAPTURE in cycle 9, res_valid in cycle 10 with res_neuron=0.
   - Neuron 1 follows: res_valid in cycle 19; done in cycle 19 (DONE state, busy high); busy low in cycle 20.
2. Same configuration, stall=1 in cycle 3:
   - group 1 issued in cycle 4; alu_accumulate in cycles 6 and 8, low in cycle 7.
   - All later events shift by +1 cycle.
3. Result capture: ALU model drives sigmoid_out=4'b0110 for neuron 0 and 4'b1000 for neuron 1 -> res_data 0110 then 1000, res_neuron 0 then 1.
4. start pulsed again in cycle 5 while busy -> ignored; exactly NUM_NEURONS res_valid pulses and one done.
5. rst asserted in cycle 7 for one cycle:
   - all outputs 0 in the same cycle, state IDLE, delay line empty.
   - no res_valid or done follows.
   - a new start then reproduces scenario 1 timing.
6. Assertion across all runs: never (alu_clear && alu_accumulate); the count of alu_accumulate pulses equals NUM_GROUPS per neuron.
